// File: rtl/cmp_serial_n.sv
// Chunk-serial integer compare/select unit: SLT/SLTU/SEQ/SNE/MIN/MINU/MAX/MAXU.
// Define CMP_EARLY_EXIT_EN to stop at the first differing chunk; otherwise every chunk is scanned.
module cmp_serial_n #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         busy
);

  localparam int NUM_CHUNKS = N / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [2:0] {
    OP_SLT  = 3'b000,
    OP_SLTU = 3'b001,
    OP_SEQ  = 3'b010,
    OP_SNE  = 3'b011,
    OP_MIN  = 3'b100,
    OP_MINU = 3'b101,
    OP_MAX  = 3'b110,
    OP_MAXU = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  state_t           state_q, state_n;
  op_t              op_q, op_n;
  logic [N-1:0]     a_q, a_n, b_q, b_n;
  logic [N-1:0]     result_q, result_n;
  logic [IDX_W-1:0] idx_q, idx_n;

  logic [CHUNK-1:0] ca, cb;
  logic             signed_op, diff, chunk_lt;
  logic             lt_n, eq_n, fin;

`ifndef CMP_EARLY_EXIT_EN
  // ne_q is the sticky "a difference has been seen" flag; eq is its complement.
  logic lt_q, lt_d, ne_q, ne_d;
`endif

  // Current chunk pair; flipping the top bit of the MSB chunk maps signed order onto unsigned.
  always_comb begin
    ca        = a_q[int'(idx_q)*CHUNK +: CHUNK];
    cb        = b_q[int'(idx_q)*CHUNK +: CHUNK];
    signed_op = (op_q == OP_SLT) || (op_q == OP_MIN) || (op_q == OP_MAX);
    if (signed_op && (idx_q == LAST_IDX)) begin
      ca[CHUNK-1] = ~ca[CHUNK-1];
      cb[CHUNK-1] = ~cb[CHUNK-1];
    end
    diff     = (ca != cb);
    chunk_lt = (ca < cb);
  end

`ifdef CMP_EARLY_EXIT_EN
  always_comb begin
    fin  = diff || (idx_q == '0);
    lt_n = diff && chunk_lt;
    eq_n = !diff;
  end
`else
  always_comb begin
    fin  = (idx_q == '0);
    lt_n = ne_q ? lt_q : (diff && chunk_lt);
    eq_n = !(ne_q || diff);
  end
`endif

  always_comb begin
    state_n  = state_q;
    op_n     = op_q;
    a_n      = a_q;
    b_n      = b_q;
    idx_n    = idx_q;
    result_n = result_q;
`ifndef CMP_EARLY_EXIT_EN
    lt_d     = lt_q;
    ne_d     = ne_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_n     = a;
          b_n     = b;
          op_n    = op_t'(op);
          idx_n   = LAST_IDX;
`ifndef CMP_EARLY_EXIT_EN
          lt_d    = 1'b0;
          ne_d    = 1'b0;
`endif
          state_n = CMP;
        end
      end
      CMP: begin
`ifndef CMP_EARLY_EXIT_EN
        lt_d = lt_n;
        ne_d = !eq_n;
`endif
        if (fin) begin
          state_n  = DONE;
          result_n = '0;
          case (op_q)
            OP_SLT, OP_SLTU: result_n[0] = lt_n;
            OP_SEQ:          result_n[0] = eq_n;
            OP_SNE:          result_n[0] = !eq_n;
            OP_MIN, OP_MINU: result_n    = lt_n ? a_q : b_q;
            OP_MAX, OP_MAXU: result_n    = lt_n ? b_q : a_q;
            default:         result_n    = '0;
          endcase
        end else begin
          idx_n = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_SLT;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      result_q <= '0;
`ifndef CMP_EARLY_EXIT_EN
      lt_q     <= 1'b0;
      ne_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      op_q     <= op_n;
      a_q      <= a_n;
      b_q      <= b_n;
      idx_q    <= idx_n;
      result_q <= result_n;
`ifndef CMP_EARLY_EXIT_EN
      lt_q     <= lt_d;
      ne_q     <= ne_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule

// File: doc/cmp_serial_n.md
Name: cmp_serial_n

Overview:
- Multi-cycle, chunk-serial integer compare/select unit for the integer-arithmetic cluster.
- Generalises the single-cycle set-less-than to eight ops: SLT, SLTU, SEQ, SNE, MIN, MINU, MAX, MAXU.
- Compares N-bit operands CHUNK bits per cycle, MSB chunk first, with early exit on the first differing chunk.
- Valid/ready handshakes on both sides so it can sit behind the issue stage without stalling the whole pipe.

Parameters:
- N, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; 1 <= CHUNK <= N.
- NUM_CHUNKS (localparam), N/CHUNK, number of chunk iterations.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- op  in  3  000 SLT, 001 SLTU, 010 SEQ, 011 SNE, 100 MIN, 101 MINU, 110 MAX, 111 MAXU.
- a  in  N  operand A.
- b  in  N  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  N  compare flag zero-extended, or selected operand.
- busy  out  1  high in CMP or DONE.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (any state, including mid-operation):
  - state=IDLE, all registers 0.
  - result=0, out_valid=0, busy=0, in_ready=1 from the first edge after rst_n releases.
  - Any in-flight operation is discarded.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: latch a, b, op; idx=NUM_CHUNKS-1; lt=0; eq=0; go to CMP.
- CMP, one chunk per edge:
  - ca=a[idx*CHUNK +: CHUNK], cb likewise.
  - For signed ops (SLT, MIN, MAX) on idx==NUM_CHUNKS-1: invert the MSB of both ca and cb, so an unsigned compare gives signed order.
  - If ca!=cb: lt=(ca<cb) unsigned, eq=0, go to DONE.
  - Else if idx==0: lt=0, eq=1, go to DONE.
  - Else idx=idx-1 and stay in CMP.
- Result formation, registered on the edge entering DONE:
  - SLT/SLTU: {N-1 zeros, lt}.
  - SEQ: {0, eq}. SNE: {0, !eq}.
  - MIN/MINU: lt ? a : b. MAX/MAXU: lt ? b : a. Equal operands return a.
- DONE:
  - out_valid=1.
  - result, out_valid and op-latched data are stable until out_valid&&out_ready at an edge, then go to IDLE.
  - in_ready=0, so in_valid is ignored.
- Latency: with k = number of chunks examined (1..NUM_CHUNKS), out_valid rises k edges after the accept edge.
  - Throughput: one op per k+2 cycles at best (accept, k compares, DONE handshake).
- Boundaries:
  - N==CHUNK: single compare cycle.
  - idx never wraps below 0.
  - op is latched, so in-flight changes to the op/a/b inputs have no effect.
  - out_ready held high in DONE: handshake completes on the first DONE edge.

Optional Feature:
- Macro: CMP_EARLY_EXIT_EN.
- Defined: early exit as described; latency depends on data (1..NUM_CHUNKS).
- Undefined: constant-time operation.
  - Every chunk is always scanned; the first differing chunk (from MSB) is recorded in sticky lt/eq flags.
  - DONE is entered only after idx==0, so latency is always NUM_CHUNKS edges.
  - Results are identical to the early-exit build.

Test Plan:
- N=32, CHUNK=8, SLT a=0xFFFFFFFF b=0x00000001 -> result=0x00000001, out_valid after 1 edge. Same operands with SLTU -> result=0x00000000.
- SEQ a=b=0x12345678 -> result=0x00000001 after 4 edges. SNE with the same operands -> 0x00000000.
- MINU a=0x00000100 b=0x000000FF -> result=0x000000FF after 3 edges. MAX a=0x80000000 b=0x7FFFFFFF -> 0x7FFFFFFF after 1 edge.
- Backpressure: out_ready=0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0, a concurrent in_valid is not accepted. out_ready=1 -> IDLE next edge, in_ready=1.
- Reset: rst_n low during the 2nd CMP cycle of SEQ -> immediately out_valid=0, result=0, busy=0. After release, a new SLTU 3 vs 5 -> 0x00000001.
- Build without CMP_EARLY_EXIT_EN: the three cases above each give out_valid exactly 4 edges after accept, with the same result values.
